console_key_injector: RTL

- Synthesisable, parametrised successor to the simulation-only console command reader.
- Buffers command characters loaded by a host/loader port into a line-committed FIFO.
- After boot, drains committed characters into the console receive path one character at a time, handshaking against the console busy flag `r_consf_en`.
- Sits between the debug/loader interconnect and the console UART model.

---
 rtl/console_key_injector_pkg.sv | 16 +
 rtl/console_key_injector_inject_fifo_mem.sv | 30 +++
 rtl/console_key_injector.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/console_key_injector_pkg.sv
// Shared definitions for the console key injector: drain FSM states and
// the line-ending characters a loader typically uses to commit a line.
package console_key_injector_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WAIT_RDY = 3'd1,
    ST_PULSE    = 3'd2,
    ST_WAIT_ACK = 3'd3,
    ST_GAP      = 3'd4
  } cki_state_e;

  localparam logic [7:0] ASCII_LF = 8'h0a;
  localparam logic [7:0] ASCII_CR = 8'h0d;

endpackage

// File: rtl/console_key_injector_inject_fifo_mem.sv
// Character storage for the key injector: a plain register array with one
// synchronous write port and one asynchronous read port. Pointer handling
// lives in the parent so this block stays a pure memory.
module inject_fifo_mem
  import console_key_injector_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Store the loader character at the write address when accepted.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/console_key_injector.sv
// Console key injector: buffers loader characters in a line-committed FIFO
// and, once the machine timer passes the boot threshold, feeds committed
// characters one at a time into the console receive path.
module console_key_injector
  import console_key_injector_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int DEPTH       = 16,
  parameter int POLL_PERIOD = 50000,
  parameter int GAP_CYCLES  = 4,
  parameter int ACK_TIMEOUT = 1024
) (
  input  logic                     clk,
  input  logic                     rst_x,
  input  logic [63:0]              w_mtime,
  input  logic [63:0]              min_time,
  input  logic                     r_consf_en,
  input  logic                     load_valid,
  input  logic [DATA_W-1:0]        load_data,
  input  logic                     load_last,
  input  logic                     load_abort,
  output logic                     load_ready,
  output logic                     we,
  output logic [DATA_W-1:0]        key,
  output logic                     boot_done,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic                     ack_timeout
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int PTR_W  = ADDR_W + 1;
  localparam int POLL_W = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;
  localparam int ACK_W  = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam int GAP_W  = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

  localparam logic [PTR_W-1:0]  DEPTH_P   = PTR_W'(DEPTH);
  localparam logic [POLL_W-1:0] POLL_LAST = POLL_W'(POLL_PERIOD - 1);
  localparam logic [ACK_W-1:0]  ACK_LAST  = ACK_W'(ACK_TIMEOUT - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_CYCLES);

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  cm_ptr_q, cm_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic              overflow_q, overflow_d;
  logic              boot_done_q, boot_done_d;
  logic [POLL_W-1:0] poll_cnt_q, poll_cnt_d;
  cki_state_e        state_q, state_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] key_q, key_d;
  logic [ACK_W-1:0]  ack_cnt_q, ack_cnt_d;
  logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
  logic              ack_timeout_q, ack_timeout_d;

  logic [PTR_W-1:0]  level_w;
  logic              full;
  logic              avail;
  logic              tick;
  logic              mem_wr_en;
  logic [DATA_W-1:0] rd_data;

  assign level_w = wr_ptr_q - rd_ptr_q;
  assign full    = (level_w == DEPTH_P);
  assign avail   = (rd_ptr_q != cm_ptr_q);
  assign tick    = (poll_cnt_q == '0);

  inject_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk     (clk),
    .wr_en   (mem_wr_en),
    .wr_addr (wr_ptr_q[ADDR_W-1:0]),
    .wr_data (load_data),
    .rd_addr (rd_ptr_q[ADDR_W-1:0]),
    .rd_data (rd_data)
  );

  // Loader side: abort rolls back to the last commit and wins over a write.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    cm_ptr_d   = cm_ptr_q;
    overflow_d = overflow_q;
    mem_wr_en  = 1'b0;
    if (load_abort) begin
      wr_ptr_d = cm_ptr_q;
    end else if (load_valid) begin
      if (full) begin
        overflow_d = 1'b1;
      end else begin
        mem_wr_en = 1'b1;
        wr_ptr_d  = wr_ptr_q + PTR_W'(1);
        if (load_last) begin
          cm_ptr_d = wr_ptr_q + PTR_W'(1);
        end
      end
    end
  end

  // Sticky boot gate and free-running poll counter.
  always_comb begin
    boot_done_d = boot_done_q | (w_mtime >= min_time);
    poll_cnt_d  = (poll_cnt_q == POLL_LAST) ? '0 : poll_cnt_q + POLL_W'(1);
  end

  // Drain sequencing: wait for console ready, strobe, wait for ack, gap.
  always_comb begin
    state_d       = state_q;
    we_d          = 1'b0;
    key_d         = key_q;
    rd_ptr_d      = rd_ptr_q;
    ack_cnt_d     = ack_cnt_q;
    gap_cnt_d     = gap_cnt_q;
    ack_timeout_d = ack_timeout_q;
    case (state_q)
      ST_IDLE: begin
        if (tick && boot_done_q && avail) begin
          state_d = ST_WAIT_RDY;
        end
      end
      ST_WAIT_RDY: begin
        if (!r_consf_en) begin
          state_d  = ST_PULSE;
          we_d     = 1'b1;
          key_d    = rd_data;
          rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
      end
      ST_PULSE: begin
        ack_cnt_d = '0;
        state_d   = ST_WAIT_ACK;
      end
      ST_WAIT_ACK: begin
        if (r_consf_en) begin
          state_d   = ST_GAP;
          gap_cnt_d = '0;
        end else if (ack_cnt_q == ACK_LAST) begin
          ack_timeout_d = 1'b1;
          state_d       = ST_GAP;
          gap_cnt_d     = '0;
        end else begin
          ack_cnt_d = ack_cnt_q + ACK_W'(1);
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          state_d = avail ? ST_WAIT_RDY : ST_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + GAP_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Loader pointers, sticky flags and poll counter.
  always_ff @(posedge clk or negedge rst_x) begin
    if (!rst_x) begin
      wr_ptr_q    <= '0;
      cm_ptr_q    <= '0;
      overflow_q  <= 1'b0;
      boot_done_q <= 1'b0;
      poll_cnt_q  <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      cm_ptr_q    <= cm_ptr_d;
      overflow_q  <= overflow_d;
      boot_done_q <= boot_done_d;
      poll_cnt_q  <= poll_cnt_d;
    end
  end

  // Drain FSM state, read pointer and registered console outputs.
  always_ff @(posedge clk or negedge rst_x) begin
    if (!rst_x) begin
      state_q       <= ST_IDLE;
      we_q          <= 1'b0;
      key_q         <= '0;
      rd_ptr_q      <= '0;
      ack_cnt_q     <= '0;
      gap_cnt_q     <= '0;
      ack_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      we_q          <= we_d;
      key_q         <= key_d;
      rd_ptr_q      <= rd_ptr_d;
      ack_cnt_q     <= ack_cnt_d;
      gap_cnt_q     <= gap_cnt_d;
      ack_timeout_q <= ack_timeout_d;
    end
  end

  assign load_ready  = !full;
  assign we          = we_q;
  assign key         = key_q;
  assign boot_done   = boot_done_q;
  assign level       = level_w;
  assign overflow    = overflow_q;
  assign ack_timeout = ack_timeout_q;

endmodule
